p_hit_2: RTL and testbench
==========================

# p_hit_2

Computes the ray/plane hit point P = origin + t·dir in signed Q(D_BITS−Q_BITS).Q_BITS fixed point, one P vector per consumed t. Sits directly downstream of `p_hit_1`: pops the scalar `t` from its output FIFO interface (`out`/`out_empty`/`out_rd_en`), pairs it in order with `origin`/`dir` buffered in its own input FIFOs, and presents the 3-component hit point through a buffered FIFO-style read interface to the barycentric/inside-triangle stage.

## Interface
- `D_BITS`, 32, data word width (signed fixed point)
- `Q_BITS`, 16, fractional bits
- `IN_DEPTH`, 16, entries in the origin/dir input FIFOs
- `OUT_DEPTH`, 4, entries in the output buffer (power of 2, ≥2)

- `clock` in 1, sole clock; all state on rising edge
- `reset` in 1, asynchronous, active-low; clears all state
- `origin[2:0]` in D_BITS×3, ray origin x,y,z
- `dir[2:0]` in D_BITS×3, ray direction x,y,z
- `in_wr_en` in 1, push origin+dir as one entry
- `in_full` out 1, origin/dir FIFOs full (OR of both)
- `t` in D_BITS, ray parameter from `p_hit_1`, valid when `t_empty`=0
- `t_empty` in 1, upstream t FIFO empty
- `t_rd_en` out 1, pops upstream t (combinational)
- `out[2:0]` out D_BITS×3, hit point head entry (first-word-fall-through)
- `out_empty` out 1, output buffer empty
- `out_rd_en` in 1, pops output head

## Operation
- Input FIFOs: first-word-fall-through; write when `in_wr_en`=1 and `in_full`=0; `in_wr_en` while full is ignored (entry dropped, no state change).
- Issue condition (cycle-combinational): `fire` = !`t_empty` && !pair_empty && (out_count + inflight < OUT_DEPTH). `t_rd_en` = `fire`; origin/dir FIFOs popped by the same `fire`. t and origin/dir are strictly matched by arrival order; neither side is popped alone.
- Stage 1 (registered on the `fire` edge): prod[i] = t × dir[i], 2·D_BITS signed; origin[i] carried; v1 ← `fire`.
- Stage 2: scaled[i] = prod[i] >>> Q_BITS (arithmetic, floor), truncated to D_BITS; p[i] = origin[i] + scaled[i], D_BITS two's-complement wrap; when v1, p written to output buffer.
- inflight = v1 (0 or 1); credit check guarantees the output buffer never overflows, so no stage stalls once issued.
- Output buffer: circular, wr/rd pointers wrap modulo OUT_DEPTH; simultaneous write and `out_rd_en` with count>0 keeps count; `out_rd_en` while `out_empty`=1 is ignored.
- No FSM beyond pipeline valid bits; t<0 and t=0 are passed through unmodified (culling is downstream).
- Reset (async assert): input FIFOs, v1, output pointers/count cleared; mid-operation in-flight results discarded. While `reset`=0: `t_rd_en`=0, `in_full`=0, `out_empty`=1, `out[*]`=0.

## Timing
- Latency: `fire` in cycle N → `out_empty`=0 with result in cycle N+2 (if buffer was empty).
- Throughput: one P per cycle while t and origin/dir available and `out_rd_en` keeps up.
- `in_full` and `out_empty` are registered-state derived (no combinational path from `in_wr_en`/`out_rd_en`).
- `t_rd_en` depends combinationally on `t_empty`; upstream must not feed `t_rd_en` back into `t_empty` combinationally.
- Output buffer full with inflight=0: `out_rd_en` in cycle N makes `fire` possible in cycle N+1 (credit from registered count).

## Configuration
- `P_HIT_SAT_EN` defined: scaled[i] saturates to [−2^(D_BITS−1), 2^(D_BITS−1)−1] if prod>>>Q_BITS exceeds D_BITS; sum p[i] saturates likewise on signed overflow.
- Undefined: both steps wrap (two's-complement truncation); no extra logic.

## Test plan
- t=0x00020000 (2.0), origin=(0x00010000,0x00020000,0x00030000), dir=(0x00010000,0,0xFFFF0000) → out=(0x00030000,0x00020000,0x00010000), `out_empty` low exactly 2 cycles after `t_rd_en`.
- origin/dir pushed 5 cycles before t arrives → `t_rd_en` stays 0 until `t_empty`=0, then single pop; t arriving first with no origin → no pop.
- `out_rd_en` held 0, 8 pairs offered → exactly 4 pops, `t_rd_en` then 0, `out_empty`=0; release `out_rd_en` continuously → remaining 4 results in order, one per cycle.
- t=0xFFFF8000 (−0.5), dir=(0x00040000,…), origin 0 → out[0]=0xFFFE0000 (−2.0); floor check t=0xFFFFFFFF, dir=0x00000001 → out[0]=0xFFFFFFFF.
- t=0x7FFF0000, dir=0x7FFF0000, origin 0: with `P_HIT_SAT_EN` → out=0x7FFFFFFF; without → wrapped low D_BITS of (prod>>>16).
- Assert `reset`=0 with 2 results buffered and 1 in flight → `out_empty`=1 immediately (async), after release no stale output appears.

Source files
------------

// File: rtl/p_hit_2.sv
// Ray/plane hit point P = origin + t*dir in signed fixed point, one P per consumed t.
// Latency: fire in cycle N -> result visible on out (out_empty=0) in cycle N+2.
// Backpressure: issue only while output buffer count + in-flight < OUT_DEPTH; no stage stalls after issue.
//
// Ports:
//   clock, reset         sole clock; asynchronous active-low reset
//   origin, dir          ray origin/direction (x,y,z), pushed together with in_wr_en
//   in_full              origin/dir buffer full (writes while full are dropped)
//   t, t_empty, t_rd_en  first-word-fall-through read side of the upstream t FIFO
//   out, out_empty,      first-word-fall-through read side of the hit point buffer
//   out_rd_en
//
// Optional build macro P_HIT_SAT_EN: saturate the scaled product and the final sum
// instead of wrapping them.

module p_hit_2 #(
   parameter int D_BITS    = 32,
   parameter int Q_BITS    = 16,
   parameter int IN_DEPTH  = 16,
   parameter int OUT_DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [2:0][D_BITS-1:0]   origin,
   input  logic [2:0][D_BITS-1:0]   dir,
   input  logic                     in_wr_en,
   output logic                     in_full,
   input  logic [D_BITS-1:0]        t,
   input  logic                     t_empty,
   output logic                     t_rd_en,
   output logic [2:0][D_BITS-1:0]   out,
   output logic                     out_empty,
   input  logic                     out_rd_en
);

   localparam int IAW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
   localparam int ICW = $clog2(IN_DEPTH + 1);
   localparam int OAW = $clog2(OUT_DEPTH);
   localparam int OCW = OAW + 1;

   // ---------------------------------------------------------------------
   // origin/dir input buffer. Both vectors share one set of pointers, so the
   // two logical FIFOs can never disagree on occupancy.
   // ---------------------------------------------------------------------
   logic [2:0][D_BITS-1:0] org_mem [IN_DEPTH];
   logic [2:0][D_BITS-1:0] dir_mem [IN_DEPTH];
   logic [IAW-1:0]         in_wr_ptr, in_rd_ptr;
   logic [ICW-1:0]         in_count;
   logic                   in_push, pair_empty, fire, credit_ok;

   function automatic logic [IAW-1:0] in_next(input logic [IAW-1:0] ptr);
      return (ptr == IAW'(IN_DEPTH - 1)) ? '0 : ptr + IAW'(1);
   endfunction

   assign in_full    = (in_count == ICW'(IN_DEPTH));
   assign pair_empty = (in_count == '0);
   assign in_push    = in_wr_en && !in_full;

   always_ff @(posedge clock) begin
      if (in_push) begin
         org_mem[in_wr_ptr] <= origin;
         dir_mem[in_wr_ptr] <= dir;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_wr_ptr <= '0;
         in_rd_ptr <= '0;
         in_count  <= '0;
      end else begin
         if (in_push) in_wr_ptr <= in_next(in_wr_ptr);
         if (fire)    in_rd_ptr <= in_next(in_rd_ptr);
         if (in_push && !fire)      in_count <= in_count + ICW'(1);
         else if (!in_push && fire) in_count <= in_count - ICW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Issue: t and origin/dir always leave together. Credit counts both the
   // buffered results and the one that may be in stage 1.
   // ---------------------------------------------------------------------
   logic [OCW-1:0] out_count;
   logic           v1;

   assign credit_ok = (out_count + OCW'(v1)) < OCW'(OUT_DEPTH);
   assign fire      = !t_empty && !pair_empty && credit_ok;
   assign t_rd_en   = fire;

   // ---------------------------------------------------------------------
   // Stage 1: full-width signed products. Operands are sign-extended to the
   // product width so the multiply is done in one self-consistent width.
   // ---------------------------------------------------------------------
   logic signed [2*D_BITS-1:0] prod [3];
   logic [2:0][D_BITS-1:0]     org1;
   logic [2:0][D_BITS-1:0]     head_dir;
   logic signed [2*D_BITS-1:0] t_ext;
   logic signed [2*D_BITS-1:0] dir_ext [3];

   assign head_dir = dir_mem[in_rd_ptr];
   assign t_ext    = {{D_BITS{t[D_BITS-1]}}, t};

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         dir_ext[i] = {{D_BITS{head_dir[i][D_BITS-1]}}, head_dir[i]};
      end
   end

   always_ff @(posedge clock) begin
      if (fire) begin
         for (int i = 0; i < 3; i++) begin
            prod[i] <= t_ext * dir_ext[i];
         end
         org1 <= org_mem[in_rd_ptr];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) v1 <= 1'b0;
      else        v1 <= fire;
   end

   // ---------------------------------------------------------------------
   // Stage 2: rescale (arithmetic shift = floor) and add the origin.
   // ---------------------------------------------------------------------
   logic [2:0][D_BITS-1:0] scaled, p;
   logic                   unused_prod;

   // Fractional and excess integer bits of the product are intentionally dropped.
   assign unused_prod = ^{prod[0], prod[1], prod[2]};

`ifdef P_HIT_SAT_EN
   localparam logic [D_BITS-1:0] SAT_MAX = {1'b0, {(D_BITS-1){1'b1}}};
   localparam logic [D_BITS-1:0] SAT_MIN = {1'b1, {(D_BITS-1){1'b0}}};
   logic [2:0][2*D_BITS-1:0] shifted;
   logic [2:0][D_BITS:0]     hi_bits;
   logic [2:0][D_BITS-1:0]   sum;

   always_comb begin
      shifted = '0;
      hi_bits = '0;
      scaled  = '0;
      sum     = '0;
      p       = '0;
      for (int i = 0; i < 3; i++) begin
         shifted[i] = prod[i] >>> Q_BITS;
         // The value fits in D_BITS only if every bit above the sign bit
         // is a copy of it.
         hi_bits[i] = shifted[i][2*D_BITS-1:D_BITS-1];
         if ((&hi_bits[i]) || !(|hi_bits[i]))
            scaled[i] = shifted[i][D_BITS-1:0];
         else
            scaled[i] = shifted[i][2*D_BITS-1] ? SAT_MIN : SAT_MAX;
         sum[i] = org1[i] + scaled[i];
         if ((org1[i][D_BITS-1] == scaled[i][D_BITS-1]) &&
             (sum[i][D_BITS-1] != org1[i][D_BITS-1]))
            p[i] = org1[i][D_BITS-1] ? SAT_MIN : SAT_MAX;
         else
            p[i] = sum[i];
      end
   end
`else
   always_comb begin
      scaled = '0;
      p      = '0;
      for (int i = 0; i < 3; i++) begin
         // Bits [Q_BITS +: D_BITS] are exactly (prod >>> Q_BITS) truncated.
         scaled[i] = prod[i][Q_BITS +: D_BITS];
         p[i]      = org1[i] + scaled[i];
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Output buffer (power-of-two depth, pointers wrap naturally).
   // ---------------------------------------------------------------------
   logic [2:0][D_BITS-1:0] out_mem [OUT_DEPTH];
   logic [OAW-1:0]         out_wr_ptr, out_rd_ptr;
   logic                   out_pop;

   assign out_empty = (out_count == '0);
   assign out_pop   = out_rd_en && !out_empty;
   // Forced to zero when empty so nothing stale shows during/after reset.
   assign out       = out_empty ? '0 : out_mem[out_rd_ptr];

   always_ff @(posedge clock) begin
      if (v1) out_mem[out_wr_ptr] <= p;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_wr_ptr <= '0;
         out_rd_ptr <= '0;
         out_count  <= '0;
      end else begin
         if (v1)      out_wr_ptr <= out_wr_ptr + OAW'(1);
         if (out_pop) out_rd_ptr <= out_rd_ptr + OAW'(1);
         if (v1 && !out_pop)      out_count <= out_count + OCW'(1);
         else if (!v1 && out_pop) out_count <= out_count - OCW'(1);
      end
   end

endmodule

// File: tb/tb_p_hit_2.sv
// Bench for p_hit_2: directed vectors, scoreboard queue filled at stimulus time,
// monitor on the falling edge pops and compares every consumed output.

module tb_p_hit_2;

   logic              clock = 1'b0;
   logic              reset;
   logic [2:0][31:0]  origin, dir, out;
   logic              in_wr_en, in_full;
   logic [31:0]       t;
   logic              t_empty, t_rd_en, out_empty, out_rd_en;

   always #5 clock = ~clock;

   p_hit_2 dut (
      .clock     (clock),
      .reset     (reset),
      .origin    (origin),
      .dir       (dir),
      .in_wr_en  (in_wr_en),
      .in_full   (in_full),
      .t         (t),
      .t_empty   (t_empty),
      .t_rd_en   (t_rd_en),
      .out       (out),
      .out_empty (out_empty),
      .out_rd_en (out_rd_en)
   );

   logic [31:0]      tq[$];
   logic [2:0][31:0] exp_q[$];
   logic [2:0][31:0] mon_exp;
   int               checks = 0;
   int               errors = 0;
   int               rd_count = 0;
   logic             fire_seen = 1'b0;

   function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return {z, y, x};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Monitor: sampled mid-cycle; a result is consumed when shown and requested.
   always @(negedge clock) begin
      fire_seen = t_rd_en;
      if (!out_empty && out_rd_en) begin
         rd_count++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL out_unexpected: got %h, expected no output", out);
         end else begin
            mon_exp = exp_q.pop_front();
            if (out !== mon_exp) begin
               errors++;
               $display("FAIL out_value: got %h, expected %h", out, mon_exp);
            end
         end
      end
   end

   // Upstream t FIFO model (first-word-fall-through).
   task automatic drive_t();
      if (tq.size() == 0) begin
         t_empty = 1'b1;
         t       = '0;
      end else begin
         t_empty = 1'b0;
         t       = tq[0];
      end
   endtask

   task automatic step();
      logic [31:0] dummy;
      @(posedge clock);
      #1;
      if (fire_seen && tq.size() > 0) dummy = tq.pop_front();
      in_wr_en = 1'b0;
      drive_t();
      #1;
   endtask

   task automatic push_pair(input logic [95:0] o, input logic [95:0] d, input logic [95:0] e);
      origin   = o;
      dir      = d;
      in_wr_en = 1'b1;
      exp_q.push_back(e);
      step();
   endtask

   task automatic push_t(input logic [31:0] v);
      tq.push_back(v);
      drive_t();
   endtask

   int pops;
   int rc0;

   initial begin
      reset     = 1'b0;
      in_wr_en  = 1'b0;
      origin    = '0;
      dir       = '0;
      out_rd_en = 1'b0;
      drive_t();
      step();
      step();

      // Reset state
      chk("rst_out_empty", 32'(out_empty), 32'd1);
      chk("rst_in_full",   32'(in_full),   32'd0);
      chk("rst_t_rd_en",   32'(t_rd_en),   32'd0);
      chk("rst_out0",      out[0],         32'h0);
      reset = 1'b1;
      step();

      // Basic vector and two-cycle latency
      out_rd_en = 1'b1;
      push_pair(v3(32'h00010000, 32'h00020000, 32'h00030000),
                v3(32'h00010000, 32'h00000000, 32'hFFFF0000),
                v3(32'h00030000, 32'h00020000, 32'h00010000));
      push_t(32'h00020000);
      #1;
      chk("t1_fire", 32'(t_rd_en), 32'd1);
      step();
      chk("t1_empty_at_n1", 32'(out_empty), 32'd1);
      step();
      chk("t1_valid_at_n2", 32'(out_empty), 32'd0);
      step();
      step();

      // origin/dir waiting for t
      push_pair(v3(32'h00010000, 32'h0, 32'h0),
                v3(32'h00010000, 32'h00010000, 32'h00010000),
                v3(32'h00020000, 32'h00010000, 32'h00010000));
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t2_wait_for_t", 32'(t_rd_en), 32'd0);
      end
      push_t(32'h00010000);
      #1;
      chk("t2_pop_on_t", 32'(t_rd_en), 32'd1);
      step();
      chk("t2_single_pop", 32'(t_rd_en), 32'd0);
      step();
      step();

      // t waiting for origin/dir
      push_t(32'h00030000);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("t2_no_pair_no_pop", 32'(t_rd_en), 32'd0);
         step();
      end
      push_pair(v3(32'h0, 32'h0, 32'h0),
                v3(32'h00010000, 32'h00020000, 32'hFFFF0000),
                v3(32'h00030000, 32'h00060000, 32'hFFFD0000));
      repeat (4) step();

      // Credit limit with a stalled consumer, then full-rate drain
      out_rd_en = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         push_pair(v3(32'(k << 16), 32'h0, 32'h0),
                   v3(32'h00010000, 32'h00010000, 32'h00010000),
                   v3(32'(k << 17), 32'(k << 16), 32'(k << 16)));
      end
      for (int k = 1; k <= 8; k++) tq.push_back(32'(k << 16));
      drive_t();
      pops = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (fire_seen) pops++;
      end
      chk("t3_pops_limited", 32'(pops), 32'd4);
      chk("t3_blocked",      32'(t_rd_en), 32'd0);
      chk("t3_out_valid",    32'(out_empty), 32'd0);
      rc0 = rd_count;
      out_rd_en = 1'b1;
      repeat (8) step();
      chk("t3_one_per_cycle", 32'(rd_count - rc0), 32'd8);
      repeat (3) step();

      // Negative t and floor rounding
      push_pair(v3(32'h0, 32'h0, 32'h0),
                v3(32'h00040000, 32'h00010000, 32'h0),
                v3(32'hFFFE0000, 32'hFFFF8000, 32'h0));
      push_t(32'hFFFF8000);
      repeat (3) step();
      push_pair(v3(32'h0, 32'h0, 32'h0),
                v3(32'h00000001, 32'h00010000, 32'h0),
                v3(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0));
      push_t(32'hFFFFFFFF);
      repeat (3) step();

      // Large product and sum overflow: saturate or wrap depending on build
`ifdef P_HIT_SAT_EN
      push_pair(v3(32'h0, 32'h7FFF0000, 32'h0),
                v3(32'h7FFF0000, 32'h00010000, 32'h0),
                v3(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0));
`else
      push_pair(v3(32'h0, 32'h7FFF0000, 32'h0),
                v3(32'h7FFF0000, 32'h00010000, 32'h0),
                v3(32'h00010000, 32'hFFFE0000, 32'h0));
`endif
      push_t(32'h7FFF0000);
      repeat (4) step();

      // Reset with two results buffered and one in flight
      out_rd_en = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         push_pair(v3(32'(k), 32'h0, 32'h0), v3(32'h0, 32'h0, 32'h0),
                   v3(32'(k), 32'h0, 32'h0));
      end
      for (int k = 1; k <= 3; k++) tq.push_back(32'h00010000);
      drive_t();
      repeat (3) step();
      chk("t6_buffered_before_reset", 32'(out_empty), 32'd0);
      reset = 1'b0;
      #1;
      chk("t6_async_empty", 32'(out_empty), 32'd1);
      chk("t6_async_out0",  out[0],         32'h0);
      exp_q.delete();
      step();
      step();
      reset     = 1'b1;
      out_rd_en = 1'b1;
      repeat (5) step();
      chk("t6_no_stale_output", 32'(out_empty), 32'd1);

      chk("end_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
